// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
//
// Purpose: loader FSM state encoding, default host handshake bytes and the
//          byte count of one little-endian stream field.
// Contents: loader_state_t, DEFAULT_ACK_BYTE, DEFAULT_DONE_BYTE, WORD_BYTES.
package program_loader_pkg;

  typedef enum logic [2:0] {
    RX_ICNT  = 3'd0,
    RX_INSTR = 3'd1,
    RX_DCNT  = 3'd2,
    RX_DATA  = 3'd3,
    ACK      = 3'd4,
    RUN      = 3'd5,
    DONE     = 3'd6
  } loader_state_t;

  localparam logic [7:0] DEFAULT_ACK_BYTE  = 8'hAA;
  localparam logic [7:0] DEFAULT_DONE_BYTE = 8'h55;
  localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - little-endian byte-to-word packer
//
// Purpose: collects four bytes into a 32-bit word, first byte in bits [7:0].
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clr_i          synchronous clear of the partial word and byte counter
//   byte_valid_i   byte_i is valid this cycle
//   byte_i         incoming byte
//   word_o         assembled word, valid while word_valid_o is high
//   word_valid_o   combinational pulse on the cycle the last byte arrives
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is usable in the same cycle it completes.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {byte_i, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART boot loader feeding instruction/data memories
//
// Purpose: parses a little-endian image (N, N instr words, M, M data words),
//          writes both memories, acks the host, runs the core until it
//          reports done, then reports DONE and waits for the next image.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   rx_valid, rx_data         received byte strobe and value
//   tx_ready, tx_valid, tx_data  outgoing byte handshake
//   io_instr_we/addr          instruction memory write port
//   io_data_we/addr           data memory write port
//   io_wdata                  write word shared by both memories
//   core_gating_signal        high while the core runs
//   core_exec_done            core finished flag
//   loading                   high while receiving the image
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         INSTR_ADDR_W = 14,
  parameter int         DATA_ADDR_W  = 16,
  parameter logic [7:0] ACK_BYTE     = DEFAULT_ACK_BYTE,
  parameter logic [7:0] DONE_BYTE    = DEFAULT_DONE_BYTE
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    io_instr_we,
  output logic [INSTR_ADDR_W-1:0] io_instr_addr,
  output logic                    io_data_we,
  output logic [DATA_ADDR_W-1:0]  io_data_addr,
  output logic [31:0]             io_wdata,
  output logic                    core_gating_signal,
  input  logic                    core_exec_done,
  output logic                    loading
);

  loader_state_t           state_q;
  logic [31:0]             instr_cnt_q;
  logic [31:0]             data_cnt_q;
  logic [31:0]             word_cnt_q;
  logic                    tx_valid_q;
  logic [7:0]              tx_data_q;
  logic                    instr_we_q;
  logic [INSTR_ADDR_W-1:0] instr_addr_q;
  logic                    data_we_q;
  logic [DATA_ADDR_W-1:0]  data_addr_q;
  logic [31:0]             wdata_q;
  logic                    gating_q;

  logic        rx_phase;
  logic [31:0] word;
  logic        word_valid;
  logic [31:0] word_cnt_inc;

  assign rx_phase     = (state_q == RX_ICNT) || (state_q == RX_INSTR) ||
                        (state_q == RX_DCNT) || (state_q == RX_DATA);
  assign word_cnt_inc = word_cnt_q + 32'd1;

  // Bytes outside the receive phase never reach the assembler, and the
  // clear keeps it empty so the next image starts on a field boundary.
  word_assembler u_word_assembler (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (!rx_phase),
    .byte_valid_i (rx_valid && rx_phase),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RX_ICNT;
      instr_cnt_q  <= '0;
      data_cnt_q   <= '0;
      word_cnt_q   <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      instr_we_q   <= 1'b0;
      instr_addr_q <= '0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      wdata_q      <= '0;
      gating_q     <= 1'b0;
    end else begin
      instr_we_q <= 1'b0;
      data_we_q  <= 1'b0;
      case (state_q)
        RX_ICNT: if (word_valid) begin
          instr_cnt_q <= word;
          word_cnt_q  <= '0;
          state_q     <= (word == 32'd0) ? RX_DCNT : RX_INSTR;
        end
        RX_INSTR: if (word_valid) begin
          instr_we_q   <= 1'b1;
          instr_addr_q <= word_cnt_q[INSTR_ADDR_W-1:0];
          wdata_q      <= word;
          word_cnt_q   <= word_cnt_inc;
          if (word_cnt_inc == instr_cnt_q) begin
            state_q <= RX_DCNT;
          end
        end
        RX_DCNT: if (word_valid) begin
          data_cnt_q <= word;
          word_cnt_q <= '0;
          if (word == 32'd0) begin
            state_q    <= ACK;
            tx_valid_q <= 1'b1;
            tx_data_q  <= ACK_BYTE;
          end else begin
            state_q <= RX_DATA;
          end
        end
        RX_DATA: if (word_valid) begin
          data_we_q   <= 1'b1;
          data_addr_q <= word_cnt_q[DATA_ADDR_W-1:0];
          wdata_q     <= word;
          word_cnt_q  <= word_cnt_inc;
          if (word_cnt_inc == data_cnt_q) begin
            state_q    <= ACK;
            tx_valid_q <= 1'b1;
            tx_data_q  <= ACK_BYTE;
          end
        end
        ACK: if (tx_valid_q && tx_ready) begin
          tx_valid_q <= 1'b0;
          gating_q   <= 1'b1;
          state_q    <= RUN;
        end
        RUN: if (core_exec_done) begin
          gating_q   <= 1'b0;
          tx_valid_q <= 1'b1;
          tx_data_q  <= DONE_BYTE;
          state_q    <= DONE;
        end
        DONE: if (tx_valid_q && tx_ready) begin
          tx_valid_q <= 1'b0;
          word_cnt_q <= '0;
          state_q    <= RX_ICNT;
        end
        default: state_q <= RX_ICNT;
      endcase
    end
  end

  assign tx_valid           = tx_valid_q;
  assign tx_data            = tx_data_q;
  assign io_instr_we        = instr_we_q;
  assign io_instr_addr      = instr_addr_q;
  assign io_data_we         = data_we_q;
  assign io_data_addr       = data_addr_q;
  assign io_wdata           = wdata_q;
  assign core_gating_signal = gating_q;
  assign loading            = rx_phase;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        io_instr_we;
  logic [13:0] io_instr_addr;
  logic        io_data_we;
  logic [15:0] io_data_addr;
  logic [31:0] io_wdata;
  logic        core_gating_signal;
  logic        core_exec_done = 1'b0;
  logic        loading;

  int errors = 0;
  int checks = 0;

  int unsigned instr_addr_log[$];
  logic [31:0] instr_data_log[$];
  int unsigned data_addr_log[$];
  logic [31:0] data_data_log[$];

  always #5 clk = ~clk;

  program_loader dut (
    .clk                (clk),
    .rstn               (rstn),
    .rx_valid           (rx_valid),
    .rx_data            (rx_data),
    .tx_ready           (tx_ready),
    .tx_valid           (tx_valid),
    .tx_data            (tx_data),
    .io_instr_we        (io_instr_we),
    .io_instr_addr      (io_instr_addr),
    .io_data_we         (io_data_we),
    .io_data_addr       (io_data_addr),
    .io_wdata           (io_wdata),
    .core_gating_signal (core_gating_signal),
    .core_exec_done     (core_exec_done),
    .loading            (loading)
  );

  always @(negedge clk) begin
    if (io_instr_we) begin
      instr_addr_log.push_back(int'(io_instr_addr));
      instr_data_log.push_back(io_wdata);
    end
    if (io_data_we) begin
      data_addr_log.push_back(int'(io_data_addr));
      data_data_log.push_back(io_wdata);
    end
  end

  task automatic clear_logs();
    instr_addr_log.delete();
    instr_data_log.delete();
    data_addr_log.delete();
    data_data_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
    end
  endtask

  // Drives ACK, RUN and DONE to completion with bounded waits.
  task automatic complete_cycle(output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    if (!tx_valid) ok = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    if (!core_gating_signal) ok = 1'b0;
    core_exec_done = 1'b1;
    @(negedge clk);
    core_exec_done = 1'b0;
    if (!tx_valid || core_gating_signal) ok = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    if (!loading || tx_valid) ok = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, io_instr_we, io_data_we, core_gating_signal} !== 12'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got tx_valid=%b tx_data=%h iwe=%b dwe=%b gate=%b, want all 0",
               tx_valid, tx_data, io_instr_we, io_data_we, core_gating_signal);
    end
    checks++;
    if (io_instr_addr !== 14'd0 || io_data_addr !== 16'd0 || io_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: got iaddr=%h daddr=%h wdata=%h, want 0", io_instr_addr,
               io_data_addr, io_wdata);
    end
    checks++;
    if (loading !== 1'b1) begin
      errors++;
      $display("FAIL reset_loading: got %b want 1", loading);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    clear_logs();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rstn = 1'b0;
    #1;
    checks++;
    if (loading !== 1'b1 || core_gating_signal !== 1'b0 || io_instr_we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got loading=%b gate=%b iwe=%b want 1/0/0", loading,
               core_gating_signal, io_instr_we);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_word(32'd1);
    send_word(32'h11223344);
    send_word(32'd0);
    #1;
    checks++;
    if (instr_addr_log.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d instr writes want 1", instr_addr_log.size());
    end else begin
      checks++;
      if (instr_addr_log[0] != 0 || instr_data_log[0] !== 32'h11223344) begin
        errors++;
        $display("FAIL midreset_word: got addr=%0d data=%h want 0/11223344",
                 instr_addr_log[0], instr_data_log[0]);
      end
    end
    complete_cycle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_cycle: got ok=%b want 1", ok);
    end
  endtask

  task automatic test_instr_words();
    bit ok;
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09;
    clear_logs();
    send_word(32'd3);
    for (int b = 1; b <= 12; b++) send_byte(8'(b));
    send_word(32'd0);
    #1;
    checks++;
    if (instr_addr_log.size() != 3 || data_addr_log.size() != 0) begin
      errors++;
      $display("FAIL instr_count: got %0d instr %0d data writes want 3/0",
               instr_addr_log.size(), data_addr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (instr_addr_log[i] != i || instr_data_log[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL instr_word%0d: got addr=%0d data=%h want %0d/%h", i,
                   instr_addr_log[i], instr_data_log[i], i, exp_w[i]);
        end
      end
    end
    complete_cycle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL instr_cycle: got ok=%b want 1", ok);
    end
  endtask

  task automatic test_data_and_ack_stall();
    clear_logs();
    send_word(32'd0);
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    #1;
    checks++;
    if (instr_addr_log.size() != 0 || data_addr_log.size() != 2) begin
      errors++;
      $display("FAIL data_count: got %0d instr %0d data writes want 0/2",
               instr_addr_log.size(), data_addr_log.size());
    end else begin
      checks++;
      if (data_addr_log[0] != 0 || data_data_log[0] !== 32'hDEADBEEF ||
          data_addr_log[1] != 1 || data_data_log[1] !== 32'h12345678) begin
        errors++;
        $display("FAIL data_words: got %0d/%h %0d/%h want 0/deadbeef 1/12345678",
                 data_addr_log[0], data_data_log[0], data_addr_log[1], data_data_log[1]);
      end
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hAA || loading !== 1'b0) begin
      errors++;
      $display("FAIL ack_start: got tx_valid=%b tx_data=%h loading=%b want 1/aa/0",
               tx_valid, tx_data, loading);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hAA || core_gating_signal !== 1'b0) begin
        errors++;
        $display("FAIL ack_stall%0d: got tx_valid=%b tx_data=%h gate=%b want 1/aa/0", c,
                 tx_valid, tx_data, core_gating_signal);
      end
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (core_gating_signal !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: got gate=%b tx_valid=%b want 1/0", core_gating_signal,
               tx_valid);
    end
  endtask

  task automatic test_run_and_done();
    int n_i;
    int n_d;
    n_i = instr_addr_log.size();
    n_d = data_addr_log.size();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h77);
    @(negedge clk);
    checks++;
    if (instr_addr_log.size() != n_i || data_addr_log.size() != n_d ||
        core_gating_signal !== 1'b1 || loading !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_rx_ignored: got iw=%0d dw=%0d gate=%b loading=%b tx_valid=%b",
               instr_addr_log.size() - n_i, data_addr_log.size() - n_d,
               core_gating_signal, loading, tx_valid);
    end
    core_exec_done = 1'b1;
    @(negedge clk);
    core_exec_done = 1'b0;
    checks++;
    if (core_gating_signal !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h55) begin
      errors++;
      $display("FAIL done_start: got gate=%b tx_valid=%b tx_data=%h want 0/1/55",
               core_gating_signal, tx_valid, tx_data);
    end
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (loading !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got loading=%b tx_valid=%b want 1/0", loading, tx_valid);
    end
  endtask

  task automatic test_second_image();
    bit ok;
    clear_logs();
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    send_word(32'd2);
    send_word(32'hA5A50001);
    core_exec_done = 1'b1;
    @(negedge clk);
    core_exec_done = 1'b0;
    checks++;
    if (core_gating_signal !== 1'b0 || loading !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rxdata_done_ignored: got gate=%b loading=%b tx_valid=%b want 0/1/0",
               core_gating_signal, loading, tx_valid);
    end
    core_exec_done = 1'b1;
    send_word(32'h00000002);
    core_exec_done = 1'b0;
    #1;
    checks++;
    if (instr_addr_log.size() != 1 || data_addr_log.size() != 2) begin
      errors++;
      $display("FAIL second_count: got %0d instr %0d data writes want 1/2",
               instr_addr_log.size(), data_addr_log.size());
    end else begin
      checks++;
      if (instr_addr_log[0] != 0 || instr_data_log[0] !== 32'hCAFEF00D ||
          data_addr_log[0] != 0 || data_data_log[0] !== 32'hA5A50001 ||
          data_addr_log[1] != 1 || data_data_log[1] !== 32'h00000002) begin
        errors++;
        $display("FAIL second_words: got i %0d/%h d %0d/%h %0d/%h", instr_addr_log[0],
                 instr_data_log[0], data_addr_log[0], data_data_log[0],
                 data_addr_log[1], data_data_log[1]);
      end
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hAA || core_gating_signal !== 1'b0) begin
      errors++;
      $display("FAIL second_ack: got tx_valid=%b tx_data=%h gate=%b want 1/aa/0",
               tx_valid, tx_data, core_gating_signal);
    end
    complete_cycle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL second_cycle: got ok=%b want 1", ok);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_instr_words();
    test_data_and_ack_stall();
    test_run_and_done();
    test_second_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
